// File: rtl/timer_req_sched_pkg.sv
// Shared definitions for timer_req_sched: timer register map, control bits and FSM states.
package timer_req_sched_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STOP,
    ST_WR_PL,
    ST_WR_PH,
    ST_GAP,
    ST_START,
    ST_RUN,
    ST_CLR,
    ST_CANCEL,
    ST_REL,
    ST_SNAP_WR,
    ST_SNAP_L0,
    ST_SNAP_L1,
    ST_SNAP_H0,
    ST_SNAP_H1,
    ST_SNAP_OUT
  } state_e;

  function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                            input logic start, input logic stop);
    logic [15:0] w;
    w = '0;
    w[CTRL_ITO]   = ito;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/timer_req_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant = '0;
    idx   = ptr;
    any   = 1'b0;
    cand  = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (req[cand]) begin
        idx = IDX_W'(cand);
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/timer_req_sched.sv
// Avalon-MM master sharing one interval timer among NUM_REQ requesters.
// Optional snapshot readback is enabled with `define TIMER_REQ_SCHED_SNAP_EN.
module timer_req_sched
  import timer_req_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_period,
  input  logic [NUM_REQ-1:0]    req_cont,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    tick,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic [2:0]            tm_address,
  output logic                  tm_chipselect,
  output logic                  tm_write_n,
  output logic [15:0]           tm_writedata,
  input  logic [15:0]           tm_readdata,
  input  logic                  tm_irq
`ifdef TIMER_REQ_SCHED_SNAP_EN
  ,
  input  logic [NUM_REQ-1:0]    snap_req,
  output logic [NUM_REQ-1:0]    snap_valid,
  output logic [31:0]           snap_value
`endif
);

  state_e             state_reg, state_next;
  logic [IDX_W-1:0]   owner_reg;
  logic [31:0]        period_reg;
  logic               cont_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               tick_sel;
  logic               done_sel;

`ifdef TIMER_REQ_SCHED_SNAP_EN
  logic [15:0]        snap_lo_reg;
  logic [31:0]        snap_value_reg;
  logic               snap_sel;
`else
  logic               unused_readdata;
  assign unused_readdata = ^tm_readdata;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
    assign owner_onehot[gi] = (owner_reg == IDX_W'(gi));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      owner_reg  <= '0;
      period_reg <= '0;
      cont_reg   <= 1'b0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Period and mode are frozen at grant; later requester changes wait for the next grant.
      if (state_reg == ST_IDLE && arb_any) begin
        owner_reg  <= arb_idx;
        period_reg <= req_period[32*arb_idx +: 32];
        cont_reg   <= |(req_cont & arb_grant);
      end
      if (state_reg == ST_REL) begin
        rr_ptr_reg <= (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + IDX_W'(1);
      end
    end
  end

`ifdef TIMER_REQ_SCHED_SNAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_lo_reg    <= '0;
      snap_value_reg <= '0;
    end else begin
      if (state_reg == ST_SNAP_L1) snap_lo_reg <= tm_readdata;
      if (state_reg == ST_SNAP_H1) snap_value_reg <= {tm_readdata, snap_lo_reg};
    end
  end
`endif

  always_comb begin
    state_next    = state_reg;
    tm_address    = '0;
    tm_chipselect = 1'b0;
    tm_write_n    = 1'b1;
    tm_writedata  = '0;
    tick_sel      = 1'b0;
    done_sel      = 1'b0;
`ifdef TIMER_REQ_SCHED_SNAP_EN
    snap_sel      = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: if (arb_any) state_next = ST_STOP;
      ST_STOP: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = REG_CONTROL;
        tm_writedata  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
        state_next    = ST_WR_PL;
      end
      ST_WR_PL: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = REG_PERIOD_L;
        tm_writedata  = period_reg[15:0];
        state_next    = ST_WR_PH;
      end
      ST_WR_PH: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = REG_PERIOD_H;
        tm_writedata  = period_reg[31:16];
        state_next    = ST_GAP;
      end
      ST_GAP: state_next = ST_START;
      ST_START: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = REG_CONTROL;
        tm_writedata  = ctrl_word(1'b1, cont_reg, 1'b1, 1'b0);
        state_next    = ST_RUN;
      end
      ST_RUN: begin
        // irq outranks cancel; cancel is re-evaluated after the clear.
        if (tm_irq) state_next = ST_CLR;
        else if (!req[owner_reg]) state_next = ST_CANCEL;
`ifdef TIMER_REQ_SCHED_SNAP_EN
        else if (snap_req[owner_reg]) state_next = ST_SNAP_WR;
`endif
      end
      ST_CLR: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = REG_STATUS;
        tick_sel      = 1'b1;
        if (!cont_reg) begin
          done_sel   = 1'b1;
          state_next = ST_REL;
        end else if (req[owner_reg]) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_CANCEL;
        end
      end
      ST_CANCEL: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = REG_CONTROL;
        tm_writedata  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
        state_next    = ST_REL;
      end
      ST_REL: state_next = ST_IDLE;
`ifdef TIMER_REQ_SCHED_SNAP_EN
      ST_SNAP_WR: begin
        tm_chipselect = 1'b1;
        tm_write_n    = 1'b0;
        tm_address    = REG_SNAP_L;
        state_next    = ST_SNAP_L0;
      end
      ST_SNAP_L0: begin
        tm_chipselect = 1'b1;
        tm_address    = REG_SNAP_L;
        state_next    = ST_SNAP_L1;
      end
      ST_SNAP_L1: begin
        tm_chipselect = 1'b1;
        tm_address    = REG_SNAP_L;
        state_next    = ST_SNAP_H0;
      end
      ST_SNAP_H0: begin
        tm_chipselect = 1'b1;
        tm_address    = REG_SNAP_H;
        state_next    = ST_SNAP_H1;
      end
      ST_SNAP_H1: begin
        tm_chipselect = 1'b1;
        tm_address    = REG_SNAP_H;
        state_next    = ST_SNAP_OUT;
      end
      ST_SNAP_OUT: begin
        snap_sel   = 1'b1;
        state_next = ST_RUN;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy  = (state_reg != ST_IDLE) && (state_reg != ST_REL);
  assign grant = busy ? owner_onehot : '0;
  assign tick  = tick_sel ? owner_onehot : '0;
  assign done  = done_sel ? owner_onehot : '0;

`ifdef TIMER_REQ_SCHED_SNAP_EN
  assign snap_valid = snap_sel ? owner_onehot : '0;
  assign snap_value = snap_value_reg;
`endif

endmodule

// File: tb/tb_timer_req_sched.sv
// Self-checking bench for timer_req_sched with a behavioural interval timer model.
`timescale 1ns/1ps
module tb_timer_req_sched;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*32-1:0] req_period = '0;
  logic [N-1:0]    req_cont = '0;
  logic [N-1:0]    grant, tick, done;
  logic            busy;
  logic [2:0]      tm_address;
  logic            tm_chipselect, tm_write_n;
  logic [15:0]     tm_writedata;
  logic [15:0]     tm_readdata;
  logic            tm_irq;
`ifdef TIMER_REQ_SCHED_SNAP_EN
  logic [N-1:0]    snap_req = '0;
  logic [N-1:0]    snap_valid;
  logic [31:0]     snap_value;
  int              snap_cnt;
  logic [31:0]     snap_last;
`endif

  always #5 clk = ~clk;

  timer_req_sched #(.NUM_REQ(N), .IDX_W(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_period    (req_period),
    .req_cont      (req_cont),
    .grant         (grant),
    .tick          (tick),
    .done          (done),
    .busy          (busy),
    .tm_address    (tm_address),
    .tm_chipselect (tm_chipselect),
    .tm_write_n    (tm_write_n),
    .tm_writedata  (tm_writedata),
    .tm_readdata   (tm_readdata),
    .tm_irq        (tm_irq)
`ifdef TIMER_REQ_SCHED_SNAP_EN
    ,
    .snap_req      (snap_req),
    .snap_valid    (snap_valid),
    .snap_value    (snap_value)
`endif
  );

  // Behavioural interval timer: counts period..0, timeout flag latched one cycle after zero.
  logic [31:0] t_period, t_cnt, t_snap;
  logic        t_run, t_cont, t_ito, t_to;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_period <= '0; t_cnt <= '0; t_snap <= '0;
      t_run <= 1'b0; t_cont <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0;
      tm_readdata <= '0;
    end else begin
      tm_readdata <= (tm_chipselect && tm_address == 3'd4) ? t_snap[15:0] :
                     (tm_chipselect && tm_address == 3'd5) ? t_snap[31:16] : 16'h0;
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to  <= 1'b1;
          t_cnt <= t_period;
          t_run <= t_cont;
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      if (tm_chipselect && !tm_write_n) begin
        case (tm_address)
          3'd0: if (!(t_run && t_cnt == 0)) t_to <= 1'b0;
          3'd1: begin
            t_ito  <= tm_writedata[0];
            t_cont <= tm_writedata[1];
            if (tm_writedata[3]) t_run <= 1'b0;
            if (tm_writedata[2]) begin
              t_run <= 1'b1;
              t_cnt <= t_period;
            end
          end
          3'd2: t_period[15:0]  <= tm_writedata;
          3'd3: t_period[31:16] <= tm_writedata;
          3'd4, 3'd5: t_snap <= t_cnt;
          default: ;
        endcase
      end
    end
  end
  assign tm_irq = t_to & t_ito;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t          exp_q[$];
  int           grant_log[$];
  int           wr_cyc[$];
  int           tick_cyc[$];
  int           tick_cnt[N];
  int           done_cnt[N];
  int           checks = 0;
  int           errors = 0;
  int           cyc_n = 0;
  logic [N-1:0] grant_prev = '0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_setup(input logic [31:0] p, input logic c);
    push_wr(3'd1, 16'h0008);
    push_wr(3'd2, p[15:0]);
    push_wr(3'd3, p[31:16]);
    push_wr(3'd1, c ? 16'h0007 : 16'h0005);
  endtask

  task automatic clear_stats();
    exp_q.delete();
    grant_log.delete();
    wr_cyc.delete();
    tick_cyc.delete();
    for (int i = 0; i < N; i++) begin
      tick_cnt[i] = 0;
      done_cnt[i] = 0;
    end
`ifdef TIMER_REQ_SCHED_SNAP_EN
    snap_cnt = 0;
`endif
  endtask

  // One clock: sample outputs 1ns after the edge and score bus writes and pulses.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (tm_chipselect && !tm_write_n) begin
      wr_cyc.push_back(cyc_n);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_write: got unexpected addr=%0d data=0x%04h", tm_address, tm_writedata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (tm_address !== e.addr || tm_writedata !== e.data) begin
          errors++;
          $display("FAIL bus_write: got addr=%0d data=0x%04h, expected addr=%0d data=0x%04h",
                   tm_address, tm_writedata, e.addr, e.data);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (tick[i]) tick_cnt[i]++;
      if (done[i]) done_cnt[i]++;
    end
    if (|tick) tick_cyc.push_back(cyc_n);
    if (|done) begin
      checks++;
      if (done !== tick) begin
        errors++;
        $display("FAIL done_with_tick: done=%b tick=%b", done, tick);
      end
    end
    if ((grant & ~grant_prev) != '0) begin
      checks++;
      if (!$onehot(grant)) begin
        errors++;
        $display("FAIL grant_onehot: grant=%b", grant);
      end
      for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
    end
`ifdef TIMER_REQ_SCHED_SNAP_EN
    if (|snap_valid) begin
      snap_cnt++;
      snap_last = snap_value;
    end
`endif
    grant_prev = grant;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      cyc();
      if (exp_q.size() == 0 && !busy && grant == '0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_idle: pending writes=%0d busy=%b, expected 0 and idle", name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    req = '0;
    reset_n = 1'b0;
    #23;
    reset_n = 1'b1;
    grant_prev = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = '1;
    #17;
    checks++;
    if (grant !== '0 || tick !== '0 || done !== '0 || busy !== 1'b0 ||
        tm_write_n !== 1'b1 || tm_chipselect !== 1'b0 || tm_address !== 3'd0 || tm_writedata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b tick=%b done=%b busy=%b write_n=%b cs=%b, expected 0 with write_n=1",
               grant, tick, done, busy, tm_write_n, tm_chipselect);
    end
    do_reset();
  endtask

  task automatic test_oneshot();
    bit ok;
    clear_stats();
    req_period[1*32 +: 32] = 32'h0000_0010;
    req_cont[1] = 1'b0;
    push_setup(32'h0000_0010, 1'b0);
    push_wr(3'd0, 16'h0000);
    req[1] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      cyc();
      if (done[1]) begin
        ok = 1'b1;
        req[1] = 1'b0;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL oneshot_done: got no done[1] within 300 cycles, expected one");
    end
    cyc();
    checks++;
    if (grant !== '0) begin
      errors++;
      $display("FAIL oneshot_release: grant=%b, expected 0000", grant);
    end
    checks++;
    if (tick_cnt[1] != 1 || done_cnt[1] != 1) begin
      errors++;
      $display("FAIL oneshot_pulses: tick=%0d done=%0d, expected 1 and 1", tick_cnt[1], done_cnt[1]);
    end
    if (wr_cyc.size() >= 4) begin
      checks++;
      if (wr_cyc[3] - wr_cyc[2] != 2) begin
        errors++;
        $display("FAIL oneshot_gap: start write %0d cycles after period_h, expected 2", wr_cyc[3] - wr_cyc[2]);
      end
    end
    wait_idle("oneshot");
  endtask

  task automatic test_continuous();
    clear_stats();
    req_period[0*32 +: 32] = 32'd100;
    req_cont[0] = 1'b1;
    push_setup(32'd100, 1'b1);
    for (int i = 0; i < 5; i++) push_wr(3'd0, 16'h0000);
    push_wr(3'd1, 16'h0008);
    req[0] = 1'b1;
    for (int k = 0; k < 1000 && tick_cnt[0] < 5; k++) begin
      cyc();
      if (tick_cnt[0] == 5) req[0] = 1'b0;
    end
    req[0] = 1'b0;
    checks++;
    if (tick_cnt[0] != 5) begin
      errors++;
      $display("FAIL cont_ticks: got %0d ticks, expected 5", tick_cnt[0]);
    end
    for (int i = 1; i < tick_cyc.size(); i++) begin
      checks++;
      if (tick_cyc[i] - tick_cyc[i-1] < 100 || tick_cyc[i] - tick_cyc[i-1] > 102) begin
        errors++;
        $display("FAIL cont_interval: got %0d cycles, expected 101", tick_cyc[i] - tick_cyc[i-1]);
      end
    end
    wait_idle("cont");
    checks++;
    if (done_cnt[0] != 0) begin
      errors++;
      $display("FAIL cont_no_done: got %0d done pulses, expected 0", done_cnt[0]);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    clear_stats();
    for (int i = 0; i < N; i++) begin
      req_period[i*32 +: 32] = 32'd5;
      req_cont[i] = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      push_setup(32'd5, 1'b0);
      push_wr(3'd0, 16'h0000);
    end
    req = '1;
    for (int k = 0; k < 2000 && req[0]; k++) begin
      cyc();
      if (grant_log.size() >= 5) begin
        req[3:1] = '0;
        if (done[0]) req[0] = 1'b0;
      end
    end
    req = '0;
    wait_idle("rr");
    checks++;
    if (grant_log.size() != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, expected 5", grant_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grant_log[i] != exp_order[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got requester %0d, expected %0d", i, grant_log[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_cancel_collision();
    bit hit;
    clear_stats();
    req_period[2*32 +: 32] = 32'd20;
    req_cont[2] = 1'b1;
    push_setup(32'd20, 1'b1);
    push_wr(3'd0, 16'h0000);
    push_wr(3'd1, 16'h0008);
    req[2] = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      cyc();
      if (tm_irq && req[2]) begin
        req[2] = 1'b0;
        hit = 1'b1;
      end
    end
    req[2] = 1'b0;
    wait_idle("collide");
    checks++;
    if (!hit || tick_cnt[2] != 1 || done_cnt[2] != 0) begin
      errors++;
      $display("FAIL collide_pulses: irq_seen=%b tick=%0d done=%0d, expected 1, 1, 0",
               hit, tick_cnt[2], done_cnt[2]);
    end
  endtask

`ifdef TIMER_REQ_SCHED_SNAP_EN
  task automatic test_snap();
    logic [31:0] v1, v2;
    clear_stats();
    v1 = '0;
    v2 = '0;
    req_period[0*32 +: 32] = 32'h0001_0000;
    req_cont[0] = 1'b1;
    push_setup(32'h0001_0000, 1'b1);
    push_wr(3'd4, 16'h0000);
    push_wr(3'd4, 16'h0000);
    push_wr(3'd1, 16'h0008);
    req[0] = 1'b1;
    repeat (10) cyc();
    for (int s = 0; s < 2; s++) begin
      snap_req[0] = 1'b1;
      cyc();
      snap_req[0] = 1'b0;
      for (int k = 0; k < 20 && snap_cnt < s + 1; k++) cyc();
      if (s == 0) v1 = snap_last;
      else v2 = snap_last;
      repeat (5) cyc();
    end
    checks++;
    if (snap_cnt != 2) begin
      errors++;
      $display("FAIL snap_count: got %0d snap_valid pulses, expected 2", snap_cnt);
    end
    checks++;
    if (v1 > 32'h0001_0000 || v1 == 0 || v2 >= v1) begin
      errors++;
      $display("FAIL snap_values: got 0x%08h then 0x%08h, expected <=0x00010000 and decreasing", v1, v2);
    end
    req[0] = 1'b0;
    wait_idle("snap");
  endtask
`endif

  initial begin
    test_reset();
    test_oneshot();
    test_continuous();
    test_round_robin();
    test_cancel_collision();
`ifdef TIMER_REQ_SCHED_SNAP_EN
    test_snap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
